// File: rtl/vga_sync_ticks.sv
// 640x480@60 Hz raster timing generator plus the game-time strobes derived from it.
module vga_sync_ticks #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned TICK_DIV  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       game_tick_60hz,
    output logic [1:0] game_tick_20hz,
    output logic       debounce_countdown_en
);

    localparam int unsigned CW      = 10;
    localparam int unsigned DW      = 2;
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_BEG  = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END  = H_DISPLAY + H_FRONT + H_SYNC;
    localparam int unsigned VS_BEG  = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END  = V_DISPLAY + V_FRONT + V_SYNC;

    logic [CW-1:0] hpos_q, hpos_d;
    logic [CW-1:0] vpos_q, vpos_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    tick20_q, tick20_d;
    logic          vpos4_q, vpos4_d;
    logic          h_wrap;
    logic          tick60;

    // Next-state logic for the raster counters, frame divider and strobe history.
    always_comb begin
        hpos_d   = hpos_q;
        vpos_d   = vpos_q;
        div_d    = div_q;
        tick20_d = 2'b00;
        vpos4_d  = vpos_q[4];
        h_wrap   = (hpos_q == CW'(H_TOTAL - 1));
        tick60   = (hpos_q == '0) && (vpos_q == CW'(V_DISPLAY));

        hpos_d = h_wrap ? '0 : hpos_q + CW'(1);
        if (h_wrap) begin
            vpos_d = (vpos_q == CW'(V_TOTAL - 1)) ? '0 : vpos_q + CW'(1);
        end

        if (tick60) begin
            div_d = (div_q == DW'(TICK_DIV - 1)) ? '0 : div_q + DW'(1);
        end

        // Phase 0 follows the divider-terminal frame tick; phase 1 trails it by one clock.
        tick20_d[0] = tick60 && (div_q == DW'(TICK_DIV - 1));
        tick20_d[1] = tick20_q[0];
    end

    // State registers; async reset also cancels a pending second 20 Hz phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q   <= '0;
            vpos_q   <= '0;
            div_q    <= '0;
            tick20_q <= '0;
            vpos4_q  <= 1'b0;
        end else begin
            hpos_q   <= hpos_d;
            vpos_q   <= vpos_d;
            div_q    <= div_d;
            tick20_q <= tick20_d;
            vpos4_q  <= vpos4_d;
        end
    end

    // Zero-latency decodes of the registered counters.
    always_comb begin
        hpos                  = hpos_q;
        vpos                  = vpos_q;
        hsync                 = !((hpos_q >= CW'(HS_BEG)) && (hpos_q < CW'(HS_END)));
        vsync                 = !((vpos_q >= CW'(VS_BEG)) && (vpos_q < CW'(VS_END)));
        display_on            = (hpos_q < CW'(H_DISPLAY)) && (vpos_q < CW'(V_DISPLAY));
        game_tick_60hz        = (hpos_q == '0) && (vpos_q == CW'(V_DISPLAY));
        game_tick_20hz        = tick20_q;
        debounce_countdown_en = vpos_q[4] & ~vpos4_q;
    end

endmodule
